// File: rtl/alu_arm_pkg.sv
// Shared definitions for the sequential ARM-style ALU: opcodes, FSM states,
// flag bit positions and opcode classification helpers.
package alu_arm_pkg;

  localparam logic [4:0] OP_AND = 5'h00;
  localparam logic [4:0] OP_EOR = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_RSB = 5'h03;
  localparam logic [4:0] OP_ADD = 5'h04;
  localparam logic [4:0] OP_ADC = 5'h05;
  localparam logic [4:0] OP_SBC = 5'h06;
  localparam logic [4:0] OP_RSC = 5'h07;
  localparam logic [4:0] OP_TST = 5'h08;
  localparam logic [4:0] OP_TEQ = 5'h09;
  localparam logic [4:0] OP_CMP = 5'h0A;
  localparam logic [4:0] OP_CMN = 5'h0B;
  localparam logic [4:0] OP_ORR = 5'h0C;
  localparam logic [4:0] OP_MOV = 5'h0D;
  localparam logic [4:0] OP_BIC = 5'h0E;
  localparam logic [4:0] OP_MVN = 5'h0F;
  localparam logic [4:0] OP_MUL = 5'h10;
  localparam logic [4:0] OP_MLA = 5'h11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Compare/test ops always set flags and never write a destination register.
  function automatic logic is_test_op(input logic [4:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_arm_mul.sv
// Iterative shift-add multiplier: one partial product per cycle over W cycles,
// optional accumulator preload, one-cycle done pulse with the low W product bits.
module alu_arm_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  input  logic         use_acc,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  prod_q, prod_d;

  // Bit 0 of the multiplier is consumed on the start edge, bits 1..W-1 afterwards.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(1);
      mcand_d  = a << 1;
      mplier_d = b >> 1;
      prod_d   = (use_acc ? acc : {W{1'b0}}) + (b[0] ? a : {W{1'b0}});
    end else if (busy_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : {W{1'b0}});
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {W{1'b0}};
      mplier_q <= {W{1'b0}};
      prod_q   <= {W{1'b0}};
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_arm_seq.sv
// Sequential ARM-style ALU: single-cycle data-processing ops, iterative
// MUL/MLA, valid/ready handshake on both sides and a registered NZCV flag set.
module alu_arm_seq
  import alu_arm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic         s,
  input  logic [W-1:0] da,
  input  logic [W-1:0] db,
  input  logic [W-1:0] dc,
  input  logic         shc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         res_we,
  output logic [3:0]   flags
);

  state_e       state_q, state_d;
  logic         s_q, s_d;
  logic [W-1:0] result_q, result_d;
  logic         res_we_q, res_we_d;
  logic [3:0]   flags_q, flags_d;

  logic         accept;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_product;
  logic [3:0]   mul_flags;

  logic [W-1:0] add_x, add_y, logic_res, dp_res;
  logic         add_cin, is_arith, dp_c, dp_v;
  logic [W:0]   sum;
  logic [3:0]   dp_flags;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign res_we    = res_we_q;
  assign flags     = flags_q;

  // Subtract-type ops add the inverted operand, so the adder carry is NOT borrow.
  always_comb begin
    add_x     = da;
    add_y     = db;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    logic_res = {W{1'b0}};
    case (op)
      OP_AND, OP_TST: logic_res = da & db;
      OP_EOR, OP_TEQ: logic_res = da ^ db;
      OP_ORR:         logic_res = da | db;
      OP_MOV:         logic_res = db;
      OP_BIC:         logic_res = da & ~db;
      OP_MVN:         logic_res = ~db;
      OP_ADD, OP_CMN: is_arith = 1'b1;
      OP_ADC: begin
        is_arith = 1'b1;
        add_cin  = flags_q[FLAG_C];
      end
      OP_SUB, OP_CMP: begin
        is_arith = 1'b1;
        add_y    = ~db;
        add_cin  = 1'b1;
      end
      OP_SBC: begin
        is_arith = 1'b1;
        add_y    = ~db;
        add_cin  = flags_q[FLAG_C];
      end
      OP_RSB: begin
        is_arith = 1'b1;
        add_x    = db;
        add_y    = ~da;
        add_cin  = 1'b1;
      end
      OP_RSC: begin
        is_arith = 1'b1;
        add_x    = db;
        add_y    = ~da;
        add_cin  = flags_q[FLAG_C];
      end
      default: logic_res = {W{1'b0}};
    endcase

    sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

    if (is_arith) begin
      dp_res = sum[W-1:0];
      dp_c   = sum[W];
      dp_v   = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
    end else begin
      dp_res = logic_res;
      dp_c   = shc;
      dp_v   = flags_q[FLAG_V];
    end

    dp_flags         = 4'b0000;
    dp_flags[FLAG_N] = dp_res[W-1];
    dp_flags[FLAG_Z] = (dp_res == {W{1'b0}});
    dp_flags[FLAG_C] = dp_c;
    dp_flags[FLAG_V] = dp_v;
  end

  // Multiply only touches N and Z.
  always_comb begin
    mul_flags         = flags_q;
    mul_flags[FLAG_N] = mul_product[W-1];
    mul_flags[FLAG_Z] = (mul_product == {W{1'b0}});
  end

  alu_arm_mul #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (da),
    .b       (db),
    .acc     (dc),
    .use_acc (op == OP_MLA),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state and result/flag capture; a new request may be taken straight from DONE.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    result_d  = result_q;
    res_we_d  = res_we_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          s_d = s;
          if (op[4]) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
            res_we_d  = 1'b0;
          end else begin
            state_d  = ST_DONE;
            result_d = dp_res;
            res_we_d = !is_test_op(op);
            if (s || is_test_op(op)) begin
              flags_d = dp_flags;
            end else begin
              flags_d = flags_q;
            end
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d  = ST_IDLE;
          res_we_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d  = ST_DONE;
          result_d = mul_product;
          res_we_d = 1'b1;
          flags_d  = s_q ? mul_flags : flags_q;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        res_we_d = 1'b0;
      end
    endcase
  end

  // Control, result and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= 1'b0;
      result_q <= {W{1'b0}};
      res_we_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      result_q <= result_d;
      res_we_q <= res_we_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_arm_seq.sv
// Self-checking bench for alu_arm_seq (W=32): directed scenarios plus random
// operations against an arithmetic reference model of the NZCV semantics.
module tb_alu_arm_seq;
  import alu_arm_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, s, shc, out_valid, out_ready, res_we;
  logic [4:0]   op;
  logic [W-1:0] da, db, dc, result;
  logic [3:0]   flags;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_arm_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .s(s), .da(da), .db(db), .dc(dc), .shc(shc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_we(res_we), .flags(flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, updates m_flags as the op completes.
  task automatic model(input logic [4:0] o, input logic sv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic sh,
                       output logic [31:0] er, output logic ewe, output int elat);
    longint m, n, sm, sn, ur, sr;
    longint cin;
    logic   ec, ev, arith, sub_type;
    logic [63:0] p;
    cin = longint'(m_flags[1]);
    ec = sh; ev = m_flags[0]; arith = 1'b0; sub_type = 1'b0;
    m = 0; n = 0; sm = 0; sn = 0; ur = 0; sr = 0; er = 32'h0;
    if (o[4]) begin
      p    = 64'(a) * 64'(b) + ((o == OP_MLA) ? 64'(c) : 64'h0);
      er   = p[31:0];
      ewe  = 1'b1;
      elat = W + 1;
      if (sv) m_flags = {er[31], er == 32'h0, m_flags[1], m_flags[0]};
    end else begin
      case (o[3:0])
        4'h0, 4'h8: er = a & b;
        4'h1, 4'h9: er = a ^ b;
        4'hC: er = a | b;
        4'hD: er = b;
        4'hE: er = a & ~b;
        4'hF: er = ~b;
        4'h4, 4'hB: begin arith = 1'b1; m = a; n = b; sm = $signed(a); sn = $signed(b); cin = 0; end
        4'h5: begin arith = 1'b1; m = a; n = b; sm = $signed(a); sn = $signed(b); end
        4'h2, 4'hA: begin arith = 1'b1; sub_type = 1'b1; m = a; n = b; sm = $signed(a); sn = $signed(b); cin = 0; end
        4'h6: begin arith = 1'b1; sub_type = 1'b1; m = a; n = b; sm = $signed(a); sn = $signed(b); cin = 1 - cin; end
        4'h3: begin arith = 1'b1; sub_type = 1'b1; m = b; n = a; sm = $signed(b); sn = $signed(a); cin = 0; end
        4'h7: begin arith = 1'b1; sub_type = 1'b1; m = b; n = a; sm = $signed(b); sn = $signed(a); cin = 1 - cin; end
        default: er = 32'h0;
      endcase
      if (arith && sub_type) begin
        ur = m - n - cin; sr = sm - sn - cin;
        er = ur[31:0]; ec = (ur >= 0);
        ev = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else if (arith) begin
        ur = m + n + cin; sr = sm + sn + cin;
        er = ur[31:0]; ec = (ur >= 64'sd4294967296);
        ev = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ewe  = !(o >= OP_TST && o <= OP_CMN);
      elat = 1;
      if (sv || !ewe) m_flags = {er[31], er == 32'h0, ec, ev};
    end
  endtask

  task automatic send(input logic [4:0] o, input logic sv, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic sh);
    int n;
    n = 0;
    op = o; s = sv; da = a; db = b; dc = c; shc = sh; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("accept_wait", 64'(n < 100), 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    da = $urandom; db = $urandom; dc = $urandom; op = 5'($urandom); s = 1'($urandom); shc = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic sv, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic sh);
    logic [31:0] er;
    logic        ewe, saw_ready;
    int          elat, k;
    model(o, sv, a, b, c, sh, er, ewe, elat);
    send(o, sv, a, b, c, sh);
    k = 1; saw_ready = 1'b0;
    while (!out_valid && k < 100) begin
      saw_ready |= in_ready;
      @(posedge clk); #1; k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(elat));
    if (elat > 1) check({tag, "_busy_ready"}, 64'(saw_ready), 64'h0);
    if (ewe) check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_res_we"}, 64'(res_we), 64'(ewe));
    check({tag, "_flags"}, 64'(flags), 64'(m_flags));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired"}, 64'(out_valid), 64'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, er2;
    logic        ewe;
    int          elat;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 5'h00; s = 1'b0;
    da = 32'h0; db = 32'h0; dc = 32'h0; shc = 1'b0; m_flags = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_flags", 64'(flags), 64'h0);
    check("rst_result", 64'(result), 64'h0);
    check("rst_res_we", 64'(res_we), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // Signed overflow on ADD, then compare, subtract-with-carry and MLA.
    run_op("add_ovf", OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
    check("add_ovf_nzcv", 64'(flags), 64'h9);
    run_op("cmp_eq", OP_CMP, 1'b0, 32'd5, 32'd5, 32'h0, 1'b0);
    check("cmp_eq_nzcv", 64'(flags), 64'h6);
    run_op("sbc", OP_SBC, 1'b1, 32'd10, 32'd3, 32'h0, 1'b0);
    check("sbc_c", 64'(flags[FLAG_C]), 64'h1);
    run_op("mla", OP_MLA, 1'b1, 32'd3, 32'd4, 32'd5, 1'b0);
    check("mla_cv", 64'(flags[1:0]), 64'h2);

    // Back-pressure in DONE: busy requests ignored, then same-edge reissue.
    model(OP_EOR, 1'b1, 32'hF0F0_1234, 32'h0FF0_0034, 32'h0, 1'b1, er, ewe, elat);
    send(OP_EOR, 1'b1, 32'hF0F0_1234, 32'h0FF0_0034, 32'h0, 1'b1);
    op = OP_ADD; s = 1'b1; da = 32'd1; db = 32'd2; shc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(out_valid), 64'h1);
      check("hold_result", 64'(result), 64'(er));
      check("hold_in_ready", 64'(in_ready), 64'h0);
      @(posedge clk); #1;
    end
    model(OP_ADD, 1'b1, 32'd1, 32'd2, 32'h0, 1'b0, er2, ewe, elat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("reissue_valid", 64'(out_valid), 64'h1);
    check("reissue_result", 64'(result), 64'(er2));
    check("reissue_flags", 64'(flags), 64'(m_flags));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply aborts it.
    send(OP_MUL, 1'b1, 32'd7, 32'd9, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    check("abort_out_valid", 64'(out_valid), 64'h0);
    check("abort_flags", 64'(flags), 64'h0);
    check("abort_in_ready", 64'(in_ready), 64'h1);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_result", 64'(out_valid), 64'h0);
    run_op("add_after_rst", OP_ADD, 1'b0, 32'd1, 32'd1, 32'h0, 1'b0);

    // MOV keeps V, takes C from the shifter.
    run_op("set_v", OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_op("mov_zero", OP_MOV, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
    check("mov_zero_nzcv", 64'(flags), 64'h7);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 5'($urandom_range(0, 31)), 1'($urandom), pick(), pick(), pick(), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arm_seq.md
ALU_ARM_SEQ -- requirements
Module: alu_arm_seq

Interface
REQ-001 Parameter W, default 32, meaning datapath width; legal range 8..64.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  operation request valid.
REQ-005 in_ready  out  1  block can accept a request this cycle.
REQ-006 op  in  5  opcode (op[4]=0 data-processing, op[4]=1 multiply), values from alu_arm_pkg.
REQ-007 s  in  1  update flags register with this operation.
REQ-008 da, db, dc  in  W each  operand A, operand B (shifter output), accumulator (MLA only).
REQ-009 shc  in  1  shifter carry-out, used as C for logical ops.
REQ-010 out_valid  out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-011 result  out  W  operation result; res_we  out  1  result to be written to Rd.
REQ-012 flags  out  4  registered {N,Z,C,V}.

Function
REQ-013 Request accepted on edge where in_valid && in_ready; operands, op, s captured in internal registers.
REQ-014 States: IDLE, MUL, DONE. in_ready=1 in IDLE, and in DONE when out_ready=1 (back-to-back issue).
REQ-015 Data-processing op: IDLE/DONE -> DONE, result valid cycle after acceptance (latency 1).
REQ-016 Multiply op: -> MUL, W cycles of one-bit shift-add, then DONE; latency W+1.
REQ-017 DONE holds result, res_we, out_valid=1 stable until out_ready; then IDLE unless new request accepted same edge.
REQ-018 Opcodes 0x00-0x0F: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN (ARM order); 0x10 MUL, 0x11 MLA; other op[4]=1 codes behave as MUL.
REQ-019 Arithmetic in W+1 bits; C = carry-out for add-type, NOT borrow for subtract-type (SUB, RSB, CMP, SBC, RSC).
REQ-020 ADC: da+db+C; SBC: da-db-(1-C); RSC: db-da-(1-C); C taken from flags register at acceptance.
REQ-021 V = signed overflow: add-type when operand signs equal and differ from result; subtract-type when minuend/subtrahend signs differ and result sign differs from minuend.
REQ-022 Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C=shc, V unchanged.
REQ-023 MUL: low W bits of da*db; MLA: low W bits of da*db+dc; C, V unchanged.
REQ-024 N=result[W-1], Z=(result==0) for all ops.
REQ-025 Flags register written on edge entering DONE iff s=1; TST TEQ CMP CMN update flags regardless of s.
REQ-026 res_we=0 for TST TEQ CMP CMN, else 1.
REQ-027 in_valid while busy (MUL, or DONE without out_ready) is ignored, not queued.
REQ-028 Operand changes after acceptance do not affect the in-flight operation.

Reset
REQ-029 reset asserted: state IDLE, flags=0000, result=0, res_we=0, out_valid=0, in_ready=1 after release.
REQ-030 Reset during MUL or DONE aborts the operation; no flag update, no result delivered.

Structure
REQ-031 alu_arm_pkg holds opcode constants, state enum, flag-index constants.
REQ-032 Iterative multiplier is sub-module alu_arm_mul (start, W-cycle done pulse, W-bit product low half).
REQ-033 Data-processing datapath is combinational inside alu_arm_seq; only captured operands, state, counter, result and flags are registered.

Verification (W=32)
REQ-034 ADD s=1, da=0x7FFFFFFF, db=1 -> result 0x80000000, res_we=1, flags N=1 Z=0 C=0 V=1, one cycle after acceptance.
REQ-035 CMP s=0, da=5, db=5 -> res_we=0, flags Z=1 C=1 N=0 V=0; then SBC s=1, da=10, db=3 -> result 7, C=1.
REQ-036 MLA da=3, db=4, dc=5 -> out_valid exactly 33 cycles after acceptance, result 17, in_ready=0 meanwhile, C/V unchanged.
REQ-037 out_ready held 0 for 5 cycles in DONE -> result, out_valid stable, second in_valid ignored; out_ready=1 with in_valid=1 -> new op accepted same edge.
REQ-038 reset pulse mid-MUL (cycle 10) -> out_valid=0, flags=0000, in_ready=1 after release; following ADD 1+1 -> 2.
REQ-039 MOV s=1, db=0, shc=1 with prior V=1 -> result 0, Z=1 C=1 V=1 N=0.
